// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state, grant encodings and default widths
package mem_port_arbiter_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and memory-side signals of the arbiter
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_valid_o;
    logic              if_stall_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_valid_o;
    logic              d_stall_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
        output if_rdata_o, if_valid_o, if_stall_o, d_rdata_o, d_valid_o, d_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, mem_ack_i, mem_rdata_i,
        input  if_rdata_o, if_valid_o, if_stall_o, d_rdata_o, d_valid_o, d_stall_o,
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and data ports
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    gnt_t          gnt;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          gnt_d, gnt_i, busy, ack, expire;

    assign bus.if_stall_o = bus.if_req_i & ~bus.if_valid_o;
    assign bus.d_stall_o  = bus.d_req_i & ~bus.d_valid_o;

    // Data wins unless fetch has already waited through STARVE_LIMIT data grants; ack beats timeout
    always_comb begin
        gnt_d     = bus.d_req_i & (~bus.if_req_i | (starve_cnt < SW'(STARVE_LIMIT)));
        gnt_i     = bus.if_req_i & ~gnt_d;
        busy      = (state == BUSY_I) | (state == BUSY_D);
        ack       = busy & bus.mem_ack_i;
        expire    = busy & ~bus.mem_ack_i & (tmo_cnt == TW'(TIMEOUT - 1));
        state_nxt = IDLE;
        case (state)
            IDLE:           state_nxt = gnt_d ? BUSY_D : (gnt_i ? BUSY_I : IDLE);
            BUSY_I, BUSY_D: state_nxt = (ack | expire) ? RESP : state;
            default:        state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Memory request, per-port responses, starvation and timeout counters
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            gnt             <= GNT_I;
            starve_cnt      <= '0;
            tmo_cnt         <= '0;
            bus.mem_req_o   <= 1'b0;
            bus.mem_we_o    <= 1'b0;
            bus.mem_addr_o  <= {ADDR_W{1'b0}};
            bus.mem_wdata_o <= {DATA_W{1'b0}};
            bus.if_rdata_o  <= {DATA_W{1'b0}};
            bus.d_rdata_o   <= {DATA_W{1'b0}};
            bus.if_valid_o  <= 1'b0;
            bus.d_valid_o   <= 1'b0;
            bus.err_o       <= 1'b0;
        end else begin
            bus.if_valid_o <= 1'b0;
            bus.d_valid_o  <= 1'b0;
            if (state == IDLE) begin
                starve_cnt <= (gnt_d & bus.if_req_i) ? starve_cnt + SW'(1) : '0;
                if (gnt_d | gnt_i) begin
                    gnt             <= gnt_t'(gnt_d);
                    tmo_cnt         <= '0;
                    bus.mem_req_o   <= 1'b1;
                    bus.mem_we_o    <= gnt_d & bus.d_we_i;
                    bus.mem_addr_o  <= gnt_d ? bus.d_addr_i : bus.if_addr_i;
                    bus.mem_wdata_o <= gnt_d ? bus.d_wdata_i : {DATA_W{1'b0}};
                end
            end else if (busy) begin
                if (ack | expire) begin
                    bus.mem_req_o <= 1'b0;
                    bus.err_o     <= bus.err_o | expire;
                    if (gnt == GNT_I) begin
                        bus.if_valid_o <= 1'b1;
                        bus.if_rdata_o <= ack ? bus.mem_rdata_i : {DATA_W{1'b0}};
                    end else begin
                        bus.d_valid_o <= 1'b1;
                        if (expire | ~bus.mem_we_o)
                            bus.d_rdata_o <= ack ? bus.mem_rdata_i : {DATA_W{1'b0}};
                    end
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written multi-cycle sequences
module tb_mem_port_arbiter;
    typedef struct packed {
        logic        rst, if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic        ack;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        mem_req, mem_we;
        logic [31:0] mem_addr, mem_wdata;
        logic        if_valid, if_stall, d_valid, d_stall;
        logic [31:0] if_rdata, d_rdata;
        logic        err;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t vt[21];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .TIMEOUT(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic in_t mi(int r, int ir, int ia, int dr, int dw, int da, int dd, int ak, int rd);
        in_t x;
        x.rst = r[0]; x.if_req = ir[0]; x.if_addr = ia;
        x.d_req = dr[0]; x.d_we = dw[0]; x.d_addr = da; x.d_wdata = dd;
        x.ack = ak[0]; x.rdata = rd;
        return x;
    endfunction

    function automatic out_t mo(int mr, int mw, int ma, int md, int iv, int is, int dv, int ds,
                                int ird, int drd, int er);
        out_t x;
        x.mem_req = mr[0]; x.mem_we = mw[0]; x.mem_addr = ma; x.mem_wdata = md;
        x.if_valid = iv[0]; x.if_stall = is[0]; x.d_valid = dv[0]; x.d_stall = ds[0];
        x.if_rdata = ird; x.d_rdata = drd; x.err = er[0];
        return x;
    endfunction

    function automatic out_t sample();
        out_t x;
        x.mem_req = bus.mem_req_o; x.mem_we = bus.mem_we_o;
        x.mem_addr = bus.mem_addr_o; x.mem_wdata = bus.mem_wdata_o;
        x.if_valid = bus.if_valid_o; x.if_stall = bus.if_stall_o;
        x.d_valid = bus.d_valid_o; x.d_stall = bus.d_stall_o;
        x.if_rdata = bus.if_rdata_o; x.d_rdata = bus.d_rdata_o; x.err = bus.err_o;
        return x;
    endfunction

    task automatic apply(input in_t x);
        rst = x.rst;
        bus.if_req_i = x.if_req; bus.if_addr_i = x.if_addr;
        bus.d_req_i = x.d_req; bus.d_we_i = x.d_we;
        bus.d_addr_i = x.d_addr; bus.d_wdata_i = x.d_wdata;
        bus.mem_ack_i = x.ack; bus.mem_rdata_i = x.rdata;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and act as the memory: ack on the ack_at-th mem_req_o cycle (0 = never)
    task automatic run(input bit is_d, input bit we, input int addr, input int wdata,
                       input int ack_at, input int rd, output int rc, output bit dn);
        rc = 0;
        dn = 1'b0;
        if (is_d) begin
            bus.d_req_i = 1'b1; bus.d_we_i = we; bus.d_addr_i = addr; bus.d_wdata_i = wdata;
        end else begin
            bus.if_req_i = 1'b1; bus.if_addr_i = addr;
        end
        for (int c = 0; c < 40 && !dn; c++) begin
            cyc();
            bus.mem_ack_i = 1'b0;
            if (bus.mem_req_o) begin
                rc++;
                if (rc == ack_at) begin
                    bus.mem_ack_i = 1'b1;
                    bus.mem_rdata_i = rd;
                end
            end
            #1;
            if (is_d ? bus.d_valid_o : bus.if_valid_o) dn = 1'b1;
        end
        bus.if_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        bus.d_we_i = 1'b0;
        bus.mem_ack_i = 1'b0;
    endtask

    initial begin
        logic [5:0] order;
        int         n, rc, nv;
        bit         dn, seen;

        vt[0]  = '{mi(0,0,0,0,0,0,0,0,0),                        mo(0,0,0,0,0,0,0,0,0,0,0)};
        vt[1]  = '{mi(1,1,'h40,0,0,0,0,0,0),                     mo(0,0,0,0,0,1,0,0,0,0,0)};
        vt[2]  = '{mi(1,1,'h40,0,0,0,0,0,0),                     mo(1,0,'h40,0,0,1,0,0,0,0,0)};
        vt[3]  = '{mi(1,1,'h40,0,0,0,0,1,'h00A00093),            mo(1,0,'h40,0,0,1,0,0,0,0,0)};
        vt[4]  = '{mi(1,1,'h40,0,0,0,0,0,0),                     mo(0,0,'h40,0,1,0,0,0,'h00A00093,0,0)};
        vt[5]  = '{mi(1,0,0,0,0,0,0,1,'hFFFFFFFF),               mo(0,0,'h40,0,0,0,0,0,'h00A00093,0,0)};
        vt[6]  = '{mi(1,0,0,0,0,0,0,0,0),                        mo(0,0,'h40,0,0,0,0,0,'h00A00093,0,0)};
        vt[7]  = '{mi(1,1,'h44,1,1,'h100,'hDEADBEEF,0,0),        mo(0,0,'h40,0,0,1,0,1,'h00A00093,0,0)};
        vt[8]  = '{mi(1,1,'h44,1,1,'h100,'hDEADBEEF,0,0),        mo(1,1,'h100,'hDEADBEEF,0,1,0,1,'h00A00093,0,0)};
        vt[9]  = '{mi(1,1,'h44,1,1,'h100,'hDEADBEEF,1,'h12345678), mo(1,1,'h100,'hDEADBEEF,0,1,0,1,'h00A00093,0,0)};
        vt[10] = '{mi(1,1,'h44,1,1,'h100,'hDEADBEEF,0,0),        mo(0,1,'h100,'hDEADBEEF,0,1,1,0,'h00A00093,0,0)};
        vt[11] = '{mi(1,1,'h44,0,0,0,0,0,0),                     mo(0,1,'h100,'hDEADBEEF,0,1,0,0,'h00A00093,0,0)};
        vt[12] = '{mi(1,1,'h44,0,0,0,0,0,0),                     mo(1,0,'h44,0,0,1,0,0,'h00A00093,0,0)};
        vt[13] = '{mi(1,1,'h44,0,0,0,0,1,'h13),                  mo(1,0,'h44,0,0,1,0,0,'h00A00093,0,0)};
        vt[14] = '{mi(1,1,'h44,0,0,0,0,0,0),                     mo(0,0,'h44,0,1,0,0,0,'h13,0,0)};
        vt[15] = '{mi(1,0,0,0,0,0,0,0,0),                        mo(0,0,'h44,0,0,0,0,0,'h13,0,0)};
        vt[16] = '{mi(1,0,0,1,0,'h200,0,0,0),                    mo(0,0,'h44,0,0,0,0,1,'h13,0,0)};
        vt[17] = '{mi(1,0,0,1,0,'h200,0,0,0),                    mo(1,0,'h200,0,0,0,0,1,'h13,0,0)};
        vt[18] = '{mi(1,0,0,1,0,'h200,0,1,'hCAFEF00D),           mo(1,0,'h200,0,0,0,0,1,'h13,0,0)};
        vt[19] = '{mi(1,0,0,1,0,'h200,0,0,0),                    mo(0,0,'h200,0,0,0,1,0,'h13,'hCAFEF00D,0)};
        vt[20] = '{mi(1,0,0,0,0,0,0,0,0),                        mo(0,0,'h200,0,0,0,0,0,'h13,'hCAFEF00D,0)};

        apply(mi(0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);

        for (int k = 0; k < 21; k++) begin
            out_t a;
            @(posedge clk);
            #1;
            apply(vt[k].i);
            #1;
            a = sample();
            total++;
            if (a !== vt[k].o) begin
                bad++;
                $display("FAIL vec%0d: got %h expected %h", k, a, vt[k].o);
            end
        end

        // Fetch held while data keeps requesting: four data grants, one fetch, then data again
        order = '0;
        n = 0;
        bus.if_req_i = 1'b1; bus.if_addr_i = 'h300;
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 'h400; bus.d_wdata_i = 0;
        for (int c = 0; c < 80 && n < 6; c++) begin
            cyc();
            bus.mem_ack_i = bus.mem_req_o;
            bus.mem_rdata_i = bus.mem_addr_o;
            #1;
            if (bus.d_valid_o) begin
                order[n] = 1'b1;
                chk("starve_d_rdata", bus.d_rdata_o, 'h400);
                n++;
            end else if (bus.if_valid_o) begin
                order[n] = 1'b0;
                chk("starve_if_rdata", bus.if_rdata_o, 'h300);
                n++;
            end
        end
        bus.if_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        bus.mem_ack_i = 1'b0;
        chk("starve_count", n, 6);
        chk("starve_order", 32'(order), 'b101111);

        // Timeout with no ack: eight request cycles, then error, pulse and zero data
        run(1'b1, 1'b0, 'h500, 0, 0, 0, rc, dn);
        chk("tmo_done", 32'(dn), 1);
        chk("tmo_req_cycles", rc, 8);
        chk("tmo_err", 32'(bus.err_o), 1);
        chk("tmo_d_rdata", bus.d_rdata_o, 0);
        chk("tmo_mem_req", 32'(bus.mem_req_o), 0);

        // Error stays set across a later good fetch
        run(1'b0, 1'b0, 'h600, 0, 1, 'h11111111, rc, dn);
        chk("good_done", 32'(dn), 1);
        chk("good_req_cycles", rc, 1);
        chk("good_if_rdata", bus.if_rdata_o, 'h11111111);
        chk("good_err_sticky", 32'(bus.err_o), 1);

        // Reset during a data write, with a late ack one cycle after
        bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_addr_i = 'h800; bus.d_wdata_i = 'h55;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cyc();
            seen = bus.mem_req_o;
        end
        chk("rst_reached_busy", 32'(seen), 1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
        bus.mem_ack_i = 1'b1; bus.mem_rdata_i = 'h99;
        #1;
        chk("rst_mem_req", 32'(bus.mem_req_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        nv = 0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            bus.mem_ack_i = 1'b0;
            #1;
            nv += int'(bus.d_valid_o | bus.if_valid_o | bus.mem_req_o);
        end
        chk("rst_no_activity", nv, 0);
        chk("rst_d_rdata", bus.d_rdata_o, 0);

        // Ack on the last allowed busy cycle beats the timeout
        run(1'b1, 1'b0, 'h700, 0, 8, 'h77777777, rc, dn);
        chk("edge_done", 32'(dn), 1);
        chk("edge_req_cycles", rc, 8);
        chk("edge_err", 32'(bus.err_o), 0);
        chk("edge_d_rdata", bus.d_rdata_o, 'h77777777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
